register_free_list_ctrl: RTL and testbench
==========================================

// Module: register_free_list_ctrl
// PURPOSE
// Controller sitting in front of register_free_list in the renamer. After reset it seeds the
// free list with physical IDs ARCH_REGS..PHYS_REGS-1. It then arbitrates NUM_RELEASE retire-side
// release ports onto the single free-list push, round-robin, and gates rename-side allocation pops.
// It also forwards rename rollbacks to the free list.
// PARAMETERS
// PHYS_REGS    64  total physical registers; power of 2; equals free list FIFO_DEPTH + ARCH_REGS
// ARCH_REGS    32  architectural registers, initially mapped and never seeded
// NUM_RELEASE  2   release (retire) ports; 1..4
// PORTS (PW = $clog2(PHYS_REGS))
// clk                in   1              clock
// rst                in   1              asynchronous reset, active-high
// init_done          out  1              seeding finished; block is in RUN
// alloc_req          in   1              rename wants one physical register this cycle
// alloc_gnt          out  1              allocation accepted this cycle
// alloc_phys_addr    out  PW             allocated ID; valid when alloc_gnt
// rollback           in   1              undo the previous cycle's allocation
// release_valid      in   NUM_RELEASE    port i offers an ID to return
// release_phys_addr  in   NUM_RELEASE*PW port i ID, slice [i*PW +: PW]
// release_ready      out  NUM_RELEASE    port i can accept
// fl_push            out  1              free list push
// fl_potential_push  out  1              free list write enable; equals fl_push
// fl_data_in         out  PW             free list write data
// fl_pop             out  1              free list pop
// fl_rollback        out  1              free list rollback
// fl_valid           in   1              free list non-empty
// fl_data_out        in   PW             free list head
// BEHAVIOUR
// - Reset: state=INIT, fill_cnt=0, all staging slots empty, rr_ptr=0.
// - Outputs during reset: init_done=0, alloc_gnt=0, release_ready=0, fl_push=0, fl_pop=0, fl_rollback=0.
// - rst must also reset register_free_list in the same cycle.
// - INIT state:
//   - fl_push=1 every cycle with fl_data_in = ARCH_REGS+fill_cnt; fill_cnt increments.
//   - After the push with fill_cnt == PHYS_REGS-ARCH_REGS-1, the next state is RUN.
//   - Seeding takes PHYS_REGS-ARCH_REGS cycles.
//   - alloc_gnt, fl_pop, fl_rollback and release_ready are all 0; alloc_req and rollback are ignored.
// - RUN state: init_done=1. The block stays in RUN until rst; there is no other transition.
// - Allocation (combinational):
//   - alloc_gnt = RUN & alloc_req & fl_valid.
//   - fl_pop = alloc_gnt; alloc_phys_addr = fl_data_out.
//   - If fl_valid=0, alloc_gnt=0 and rename stalls; there is no buffering.
// - Rollback: fl_rollback = RUN & rollback. Caller guarantees it follows a granted allocation.
// - Release staging: one ID slot per port.
//   - release_ready[i] = RUN & (~slot_full[i] | grant[i]).
//   - Slot loads on release_valid[i] & release_ready[i].
//   - Load and drain of the same slot in one cycle keeps the slot full with the new ID.
// - Release arbitration:
//   - grant = first full slot at or after (rr_ptr+1) mod NUM_RELEASE. At most one grant per cycle.
//   - When a grant occurs: fl_push=1, fl_data_in = that slot's ID, slot clears (unless reloaded),
//     rr_ptr <= granted index. No grant leaves rr_ptr unchanged.
// - Latency: a released ID is pushed no earlier than 1 cycle after acceptance.
//   It is poppable (fl_valid) the cycle after the push.
// - A push and a pop in the same cycle are legal. The free list cannot overflow, because at most
//   PHYS_REGS-ARCH_REGS IDs are ever free. The bench asserts ~(fl_push & fl_valid & full).
// - Reset mid-operation: staged IDs are discarded and the block reseeds from ARCH_REGS.
// - Widths: fill_cnt is $clog2(PHYS_REGS-ARCH_REGS)+1 bits; rr_ptr is max(1,$clog2(NUM_RELEASE)) bits.
// TESTING
// - Seeding (defaults): release rst -> fl_data_in 32,33,...,63 on 32 consecutive cycles;
//   init_done rises on cycle 33; alloc_req=1 throughout INIT gives alloc_gnt=0.
// - Allocation: after init, alloc_req for 3 cycles -> alloc_phys_addr 32,33,34 and fl_pop=1
//   each cycle. With 32 allocations done and no releases, the 33rd request sees fl_valid=0 and alloc_gnt=0.
// - Simultaneous release: ports 0 and 1 present 5 and 7 in the same cycle, rr_ptr=0
//   -> push 7, then push 5 on the next cycle; release_ready stays 1 for the drained ports.
// - Back-to-back release on one port: 9,10,11 on consecutive cycles with the other port idle
//   -> pushes 9,10,11 on consecutive cycles, one cycle later.
// - Rollback: allocate 32, then rollback=1 on the next cycle -> fl_rollback=1; the next alloc returns 32.
// - Reset mid-seed: assert rst at fill_cnt=10 -> outputs zero immediately; seeding restarts at 32.

Source files
------------

// File: rtl/register_free_list_ctrl.sv
// -----------------------------------------------------------------------------
// register_free_list_ctrl
//
// Front-end controller for the renamer's register_free_list.
//   * After reset it seeds the free list with physical IDs ARCH_REGS..PHYS_REGS-1,
//     one push per cycle, then moves to RUN for good.
//   * In RUN it gates rename-side allocation pops on free-list occupancy,
//     forwards rollbacks, and merges NUM_RELEASE retire-side release ports onto
//     the single free-list push through one staging slot per port and a
//     round-robin arbiter.
//
// Ports (PW = $clog2(PHYS_REGS))
//   clk_i                in   1               clock
//   rst_i                in   1               asynchronous reset, active-high
//   init_done_o          out  1               seeding finished (RUN state)
//   alloc_req_i          in   1               rename wants one physical register
//   alloc_gnt_o          out  1               allocation accepted this cycle
//   alloc_phys_addr_o    out  PW              allocated ID, valid with alloc_gnt_o
//   rollback_i           in   1               undo previous cycle's allocation
//   release_valid_i      in   NUM_RELEASE     port i offers an ID
//   release_phys_addr_i  in   NUM_RELEASE*PW  port i ID in slice [i*PW +: PW]
//   release_ready_o      out  NUM_RELEASE     port i can accept
//   fl_push_o            out  1               free-list push
//   fl_potential_push_o  out  1               free-list write enable (= fl_push_o)
//   fl_data_in_o         out  PW              free-list write data
//   fl_pop_o             out  1               free-list pop
//   fl_rollback_o        out  1               free-list rollback
//   fl_valid_i           in   1               free list non-empty
//   fl_data_out_i        in   PW              free-list head
// -----------------------------------------------------------------------------
module register_free_list_ctrl #(
  parameter int PHYS_REGS   = 64,
  parameter int ARCH_REGS   = 32,
  parameter int NUM_RELEASE = 2
) (
  input  logic                                    clk_i,
  input  logic                                    rst_i,
  output logic                                    init_done_o,
  input  logic                                    alloc_req_i,
  output logic                                    alloc_gnt_o,
  output logic [$clog2(PHYS_REGS)-1:0]            alloc_phys_addr_o,
  input  logic                                    rollback_i,
  input  logic [NUM_RELEASE-1:0]                  release_valid_i,
  input  logic [NUM_RELEASE*$clog2(PHYS_REGS)-1:0] release_phys_addr_i,
  output logic [NUM_RELEASE-1:0]                  release_ready_o,
  output logic                                    fl_push_o,
  output logic                                    fl_potential_push_o,
  output logic [$clog2(PHYS_REGS)-1:0]            fl_data_in_o,
  output logic                                    fl_pop_o,
  output logic                                    fl_rollback_o,
  input  logic                                    fl_valid_i,
  input  logic [$clog2(PHYS_REGS)-1:0]            fl_data_out_i
);

  localparam int PW   = $clog2(PHYS_REGS);
  localparam int SEED = PHYS_REGS - ARCH_REGS;
  localparam int FW   = $clog2(SEED) + 1;
  localparam int RW   = (NUM_RELEASE > 1) ? $clog2(NUM_RELEASE) : 1;

  localparam logic [FW-1:0] LAST_FILL = FW'(SEED - 1);
  localparam logic [PW-1:0] ARCH_ID   = PW'(ARCH_REGS);

  typedef enum logic [0:0] {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  state_e                         state_q, state_d;
  logic [FW-1:0]                  fill_cnt_q, fill_cnt_d;
  logic [NUM_RELEASE-1:0]         slot_full_q, slot_full_d;
  logic [NUM_RELEASE-1:0][PW-1:0] slot_id_q, slot_id_d;
  logic [RW-1:0]                  rr_ptr_q, rr_ptr_d;

  logic                           run_s;
  logic [NUM_RELEASE-1:0]         grant_s;
  logic [RW-1:0]                  grant_idx_s;
  logic                           grant_any_s;
  logic [NUM_RELEASE-1:0]         load_s;

  assign run_s = (state_q == ST_RUN);

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= ST_INIT;
    end else begin
      state_q <= state_d;
    end
  end

  // Datapath registers: seed counter, staging slots, round-robin pointer
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      fill_cnt_q  <= '0;
      slot_full_q <= '0;
      slot_id_q   <= '0;
      rr_ptr_q    <= '0;
    end else begin
      fill_cnt_q  <= fill_cnt_d;
      slot_full_q <= slot_full_d;
      slot_id_q   <= slot_id_d;
      rr_ptr_q    <= rr_ptr_d;
    end
  end

  // Next-state logic: INIT runs until the last seed is pushed, RUN is terminal
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_INIT: begin
        if (fill_cnt_q == LAST_FILL) begin
          state_d = ST_RUN;
        end else begin
          state_d = ST_INIT;
        end
      end
      ST_RUN:  state_d = ST_RUN;
      default: state_d = ST_INIT;
    endcase
  end

  // Round-robin arbiter: first full slot searching from rr_ptr+1 upward
  always_comb begin
    logic [RW-1:0] cand_v;
    grant_s     = '0;
    grant_idx_s = '0;
    grant_any_s = 1'b0;
    cand_v      = '0;
    for (int k = 0; k < NUM_RELEASE; k++) begin
      cand_v = RW'((int'(rr_ptr_q) + 1 + k) % NUM_RELEASE);
      if (run_s && !grant_any_s && slot_full_q[cand_v]) begin
        grant_any_s     = 1'b1;
        grant_idx_s     = cand_v;
        grant_s[cand_v] = 1'b1;
      end else begin
        grant_any_s = grant_any_s;
      end
    end
  end

  // Datapath next-state: a load wins over a drain of the same slot
  always_comb begin
    fill_cnt_d  = fill_cnt_q;
    slot_full_d = slot_full_q;
    slot_id_d   = slot_id_q;
    rr_ptr_d    = rr_ptr_q;
    if (state_q == ST_INIT) begin
      fill_cnt_d = fill_cnt_q + FW'(1);
    end else begin
      fill_cnt_d = fill_cnt_q;
    end
    if (grant_any_s) begin
      rr_ptr_d = grant_idx_s;
    end else begin
      rr_ptr_d = rr_ptr_q;
    end
    for (int i = 0; i < NUM_RELEASE; i++) begin
      if (load_s[i]) begin
        slot_full_d[i] = 1'b1;
        slot_id_d[i]   = release_phys_addr_i[i*PW +: PW];
      end else if (grant_s[i]) begin
        slot_full_d[i] = 1'b0;
      end else begin
        slot_full_d[i] = slot_full_q[i];
      end
    end
  end

  // Outputs: allocation gating, release handshake and free-list push mux
  always_comb begin
    init_done_o       = run_s;
    alloc_gnt_o       = run_s & alloc_req_i & fl_valid_i;
    fl_pop_o          = run_s & alloc_req_i & fl_valid_i;
    alloc_phys_addr_o = fl_data_out_i;
    fl_rollback_o     = run_s & rollback_i;
    // A slot being drained this cycle can take a new ID at the same edge.
    if (run_s) begin
      release_ready_o = ~slot_full_q | grant_s;
    end else begin
      release_ready_o = '0;
    end
    load_s = release_valid_i & release_ready_o;
    // The seeding push is gated by rst_i so the free list sees no push while reset is held.
    if (rst_i) begin
      fl_push_o    = 1'b0;
      fl_data_in_o = '0;
    end else if (state_q == ST_INIT) begin
      fl_push_o    = 1'b1;
      fl_data_in_o = ARCH_ID + PW'(fill_cnt_q);
    end else if (grant_any_s) begin
      fl_push_o    = 1'b1;
      fl_data_in_o = slot_id_q[grant_idx_s];
    end else begin
      fl_push_o    = 1'b0;
      fl_data_in_o = '0;
    end
    fl_potential_push_o = fl_push_o;
  end

endmodule

// File: tb/tb_register_free_list_ctrl.sv
// -----------------------------------------------------------------------------
// Bench for register_free_list_ctrl. The free list is modelled as a queue that
// also serves as the reference for allocation results; the controller reference
// tracks seed progress, staged release IDs per port and the last granted port.
// -----------------------------------------------------------------------------
module tb_register_free_list_ctrl;

  localparam int PHYS = 64;
  localparam int ARCH = 32;
  localparam int NR   = 2;
  localparam int PW   = 6;
  localparam int SEED = PHYS - ARCH;

  logic             clk = 1'b0;
  logic             rst;
  logic             init_done;
  logic             alloc_req;
  logic             alloc_gnt;
  logic [PW-1:0]    alloc_addr;
  logic             rollback;
  logic [NR-1:0]    rel_valid;
  logic [NR*PW-1:0] rel_addr;
  logic [NR-1:0]    rel_ready;
  logic             fl_push;
  logic             fl_ppush;
  logic [PW-1:0]    fl_data_in;
  logic             fl_pop;
  logic             fl_rollback;
  logic             fl_valid;
  logic [PW-1:0]    fl_data_out;

  always #5 clk = ~clk;

  register_free_list_ctrl #(
    .PHYS_REGS  (PHYS),
    .ARCH_REGS  (ARCH),
    .NUM_RELEASE(NR)
  ) dut (
    .clk_i              (clk),
    .rst_i              (rst),
    .init_done_o        (init_done),
    .alloc_req_i        (alloc_req),
    .alloc_gnt_o        (alloc_gnt),
    .alloc_phys_addr_o  (alloc_addr),
    .rollback_i         (rollback),
    .release_valid_i    (rel_valid),
    .release_phys_addr_i(rel_addr),
    .release_ready_o    (rel_ready),
    .fl_push_o          (fl_push),
    .fl_potential_push_o(fl_ppush),
    .fl_data_in_o       (fl_data_in),
    .fl_pop_o           (fl_pop),
    .fl_rollback_o      (fl_rollback),
    .fl_valid_i         (fl_valid),
    .fl_data_out_i      (fl_data_out)
  );

  int n_chk  = 0;
  int n_fail = 0;

  // reference state
  int  m_seed;
  bit  m_full [NR];
  int  m_id   [NR];
  int  m_last;
  int  fl_q [$];
  int  fl_last_pop;

  // expected outputs for the current cycle
  logic          e_init, e_gnt, e_pop, e_rb, e_push;
  int            e_addr, e_din, e_g;
  logic [NR-1:0] e_rdy;

  // random-phase bookkeeping: IDs held by rename, pending offers per port
  int  out_q [$];
  bit  pend [NR];
  int  pid  [NR];
  logic prev_gnt;

  typedef struct {
    logic       a;
    logic       rb;
    logic [1:0] rv;
    int         a0;
    int         a1;
    logic       x_gnt;
    int         x_addr;
    logic       x_push;
    int         x_din;
    logic       x_rb;
    logic [1:0] x_rdy;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_seed      = 0;
    m_last      = 0;
    fl_last_pop = -1;
    fl_q.delete();
    for (int i = 0; i < NR; i++) begin
      m_full[i] = 1'b0;
      m_id[i]   = 0;
    end
  endtask

  task automatic clear_stim();
    out_q.delete();
    prev_gnt = 1'b0;
    for (int i = 0; i < NR; i++) begin
      pend[i] = 1'b0;
      pid[i]  = 0;
    end
  endtask

  task automatic compute_exp();
    int idx;
    e_init = 0; e_gnt = 0; e_addr = 0; e_pop = 0; e_rb = 0;
    e_push = 0; e_din = 0; e_rdy = '0; e_g = -1;
    if (!rst) begin
      if (m_seed < SEED) begin
        e_push = 1'b1;
        e_din  = ARCH + m_seed;
      end else begin
        e_init = 1'b1;
        if (alloc_req && fl_q.size() > 0) begin
          e_gnt  = 1'b1;
          e_pop  = 1'b1;
          e_addr = fl_q[0];
        end
        e_rb = rollback;
        for (int k = 1; k <= NR; k++) begin
          idx = (m_last + k) % NR;
          if (e_g < 0 && m_full[idx]) e_g = idx;
        end
        if (e_g >= 0) begin
          e_push = 1'b1;
          e_din  = m_id[e_g];
        end
        for (int i = 0; i < NR; i++) e_rdy[i] = !m_full[i] || (e_g == i);
      end
    end
  endtask

  // Compare every output at the falling edge against the reference.
  task automatic sample();
    @(negedge clk);
    compute_exp();
    chk("init_done", 32'(init_done), 32'(e_init));
    chk("alloc_gnt", 32'(alloc_gnt), 32'(e_gnt));
    if (e_gnt) chk("alloc_addr", 32'(alloc_addr), 32'(e_addr));
    chk("fl_pop", 32'(fl_pop), 32'(e_pop));
    chk("fl_rollback", 32'(fl_rollback), 32'(e_rb));
    chk("fl_push", 32'(fl_push), 32'(e_push));
    chk("fl_potential_push", 32'(fl_ppush), 32'(e_push));
    if (e_push) chk("fl_data_in", 32'(fl_data_in), 32'(e_din));
    chk("release_ready", 32'(rel_ready), 32'(e_rdy));
  endtask

  // Apply the rising edge to the reference and refresh the free-list outputs.
  task automatic advance();
    int p;
    @(posedge clk);
    if (rst) begin
      model_reset();
    end else begin
      p = -1;
      if (e_pop) p = fl_q.pop_front();
      if (e_rb && fl_last_pop >= 0) fl_q.push_front(fl_last_pop);
      if (e_push) begin
        fl_q.push_back(e_din);
        chk("no_overflow", 32'(fl_q.size() <= SEED), 32'd1);
      end
      fl_last_pop = p;
      if (m_seed < SEED) begin
        m_seed++;
      end else begin
        if (e_g >= 0) begin
          m_full[e_g] = 1'b0;
          m_last      = e_g;
        end
        for (int i = 0; i < NR; i++) begin
          if (rel_valid[i] && e_rdy[i]) begin
            m_full[i] = 1'b1;
            m_id[i]   = int'(rel_addr[i*PW +: PW]);
          end
        end
      end
    end
    #1;
    fl_valid    = (fl_q.size() > 0);
    fl_data_out = (fl_q.size() > 0) ? PW'(fl_q[0]) : '0;
  endtask

  initial begin
    int tmp;

    //            a    rb   rv     a0 a1  gnt  addr push din rb   rdy
    tbl[0]  = '{1'b1,1'b0,2'b00, 0, 0,1'b1,32,1'b0, 0,1'b0,2'b11};
    tbl[1]  = '{1'b1,1'b0,2'b00, 0, 0,1'b1,33,1'b0, 0,1'b0,2'b11};
    tbl[2]  = '{1'b1,1'b0,2'b00, 0, 0,1'b1,34,1'b0, 0,1'b0,2'b11};
    tbl[3]  = '{1'b0,1'b1,2'b00, 0, 0,1'b0, 0,1'b0, 0,1'b1,2'b11};
    tbl[4]  = '{1'b1,1'b0,2'b00, 0, 0,1'b1,34,1'b0, 0,1'b0,2'b11};
    tbl[5]  = '{1'b1,1'b0,2'b11, 5, 7,1'b1,35,1'b0, 0,1'b0,2'b11};
    tbl[6]  = '{1'b0,1'b0,2'b00, 0, 0,1'b0, 0,1'b1, 7,1'b0,2'b10};
    tbl[7]  = '{1'b0,1'b0,2'b00, 0, 0,1'b0, 0,1'b1, 5,1'b0,2'b11};
    tbl[8]  = '{1'b1,1'b0,2'b01, 9, 0,1'b1,36,1'b0, 0,1'b0,2'b11};
    tbl[9]  = '{1'b0,1'b0,2'b01,10, 0,1'b0, 0,1'b1, 9,1'b0,2'b11};
    tbl[10] = '{1'b0,1'b0,2'b01,11, 0,1'b0, 0,1'b1,10,1'b0,2'b11};
    tbl[11] = '{1'b0,1'b0,2'b00, 0, 0,1'b0, 0,1'b1,11,1'b0,2'b11};
    tbl[12] = '{1'b0,1'b0,2'b00, 0, 0,1'b0, 0,1'b0, 0,1'b0,2'b11};

    rst = 1'b1; alloc_req = 1'b0; rollback = 1'b0;
    rel_valid = '0; rel_addr = '0; fl_valid = 1'b0; fl_data_out = '0;
    model_reset();
    clear_stim();

    // Reset held: all outputs quiet.
    repeat (2) begin
      sample();
      advance();
    end
    rst = 1'b0;

    // Seeding with alloc_req held high: no grants, IDs 32..63.
    alloc_req = 1'b1;
    for (int k = 0; k < SEED; k++) begin
      sample();
      chk("seed_data", 32'(fl_data_in), 32'(ARCH + k));
      chk("seed_no_gnt", 32'(alloc_gnt), 32'd0);
      advance();
    end

    // Directed table: allocation, rollback, simultaneous and back-to-back release.
    for (int r = 0; r < 13; r++) begin
      alloc_req = tbl[r].a;
      rollback  = tbl[r].rb;
      rel_valid = tbl[r].rv;
      rel_addr  = {PW'(tbl[r].a1), PW'(tbl[r].a0)};
      sample();
      chk($sformatf("tbl%0d_init_done", r), 32'(init_done), 32'd1);
      chk($sformatf("tbl%0d_gnt", r), 32'(alloc_gnt), 32'(tbl[r].x_gnt));
      if (tbl[r].x_gnt) chk($sformatf("tbl%0d_addr", r), 32'(alloc_addr), 32'(tbl[r].x_addr));
      chk($sformatf("tbl%0d_push", r), 32'(fl_push), 32'(tbl[r].x_push));
      if (tbl[r].x_push) chk($sformatf("tbl%0d_din", r), 32'(fl_data_in), 32'(tbl[r].x_din));
      chk($sformatf("tbl%0d_rb", r), 32'(fl_rollback), 32'(tbl[r].x_rb));
      chk($sformatf("tbl%0d_rdy", r), 32'(rel_ready), 32'(tbl[r].x_rdy));
      advance();
    end
    rollback = 1'b0; rel_valid = '0; rel_addr = '0;

    // Drain all 32 free IDs; the next request must stall.
    alloc_req = 1'b1;
    for (int k = 0; k < SEED; k++) begin
      sample();
      advance();
    end
    sample();
    chk("empty_fl_valid", 32'(fl_valid), 32'd0);
    chk("empty_alloc_gnt", 32'(alloc_gnt), 32'd0);
    advance();

    // Reset mid-seed at fill_cnt = 10.
    rst = 1'b1; alloc_req = 1'b0;
    sample();
    advance();
    rst = 1'b0;
    for (int k = 0; k < 10; k++) begin
      alloc_req = 1'($urandom_range(0, 1));
      sample();
      advance();
    end
    rst = 1'b1;
    model_reset();
    clear_stim();
    fl_valid = 1'b0; fl_data_out = '0;
    #1;
    chk("midrst_push", 32'(fl_push), 32'd0);
    chk("midrst_init_done", 32'(init_done), 32'd0);
    chk("midrst_ready", 32'(rel_ready), 32'd0);
    chk("midrst_gnt", 32'(alloc_gnt), 32'd0);
    chk("midrst_pop", 32'(fl_pop), 32'd0);
    chk("midrst_rb", 32'(fl_rollback), 32'd0);
    sample();
    advance();
    rst = 1'b0;
    for (int k = 0; k < SEED; k++) begin
      alloc_req = 1'($urandom_range(0, 1));
      sample();
      chk("reseed_data", 32'(fl_data_in), 32'(ARCH + k));
      advance();
    end

    // Randomized traffic; released IDs are only ones rename currently holds.
    for (int c = 0; c < 1500; c++) begin
      alloc_req = 1'($urandom_range(0, 1));
      rollback  = 1'b0;
      if (prev_gnt && $urandom_range(0, 3) == 0) begin
        rollback  = 1'b1;
        alloc_req = 1'b0;
      end
      for (int i = 0; i < NR; i++) begin
        if (!pend[i] && out_q.size() >= 2 && $urandom_range(0, 2) != 0) begin
          pend[i] = 1'b1;
          pid[i]  = out_q.pop_front();
        end
        rel_valid[i]          = pend[i];
        rel_addr[i*PW +: PW]  = PW'(pid[i]);
      end
      sample();
      advance();
      if (rollback) tmp = out_q.pop_back();
      if (e_gnt) out_q.push_back(e_addr);
      for (int i = 0; i < NR; i++) begin
        if (rel_valid[i] && e_rdy[i]) pend[i] = 1'b0;
      end
      prev_gnt = e_gnt;
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
